// File: rtl/fetch_ctrl_if.sv
// Purpose: fetch_ctrl bus interface between run control/decode and the fetch sequencer.
// Ports (master drives control, slave is fetch_ctrl):
//   start, start_addr                  run control: begin execution at start_addr
//   stall, halt, branch_en, branch_off  decode feedback for the current word
//   jump_en, jump_target               absolute jump request
//   pc_out, instr_valid, busy, done    fetch status / ROM address
//   instr_count                        retired-instruction count (0 unless FETCH_PERF_EN)
interface fetch_ctrl_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned OFF_W  = 8
);
   localparam int unsigned CNT_W = 16;

   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic              stall;
   logic              halt;
   logic              branch_en;
   logic [OFF_W-1:0]  branch_off;
   logic              jump_en;
   logic [ADDR_W-1:0] jump_target;
   logic [ADDR_W-1:0] pc_out;
   logic              instr_valid;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  instr_count;

   modport master (
      output start, start_addr, stall, halt, branch_en, branch_off, jump_en, jump_target,
      input  pc_out, instr_valid, busy, done, instr_count
   );

   modport slave (
      input  start, start_addr, stall, halt, branch_en, branch_off, jump_en, jump_target,
      output pc_out, instr_valid, busy, done, instr_count
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Purpose: program counter and fetch sequencer (IDLE/FETCH/DONE) for the 9-bit-instruction
//          core. Drives the combinational ROM address and flags the word consumed by decode.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_ctrl_if.slave: start/start_addr, stall, halt, branch_en/branch_off,
//          jump_en/jump_target in; pc_out, instr_valid, busy, done, instr_count out
// Optional feature: define FETCH_PERF_EN to build the saturating retired-instruction
//          counter; otherwise instr_count is tied to 0.
module fetch_ctrl #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned OFF_W  = 8
) (
   input logic         clk,
   input logic         rst_n,
   fetch_ctrl_if.slave bus
);
   localparam int unsigned EXT_W = ADDR_W - OFF_W;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              done_q;
   logic [ADDR_W-1:0] br_off;
   logic              start_ok;
   logic              consume;

   // Start is only honoured when no program is running.
   assign start_ok = bus.start && (state_q != S_FETCH);
   // The word at pc_out is consumed in FETCH whenever decode is not stalled.
   assign consume  = (state_q == S_FETCH) && !bus.stall;
   assign br_off   = {{EXT_W{bus.branch_off[OFF_W-1]}}, bus.branch_off};

   // Next-pc selection: halt > jump > branch > sequential; math wraps modulo 2**ADDR_W.
   always_comb begin
      pc_d = pc_q;
      if (start_ok) begin
         pc_d = bus.start_addr;
      end else if (consume && !bus.halt) begin
         if (bus.jump_en) begin
            pc_d = bus.jump_target;
         end else if (bus.branch_en) begin
            pc_d = pc_q + br_off;
         end else begin
            pc_d = pc_q + ADDR_W'(1);
         end
      end
   end

   // Sequencer state, pc and done flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         pc_q <= pc_d;
         case (state_q)
            S_IDLE: begin
               if (bus.start) state_q <= S_FETCH;
            end
            S_FETCH: begin
               if (consume && bus.halt) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               if (bus.start) begin
                  state_q <= S_FETCH;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc_out      = pc_q;
   assign bus.busy        = (state_q == S_FETCH);
   assign bus.instr_valid = consume;
   assign bus.done        = done_q;

`ifdef FETCH_PERF_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating count of consumed words; an accepted start never coincides with a valid word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (start_ok) begin
         cnt_q <= '0;
      end else if (consume && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.instr_count = cnt_q;
`else
   assign bus.instr_count = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: self-checking bench for fetch_ctrl: directed scenarios followed by random
//          control traffic, all compared against a behavioural model of the sequencer.
module tb_fetch_ctrl;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned OFF_W  = 8;

   logic clk;
   logic rst_n;

   fetch_ctrl_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) bus ();

   fetch_ctrl #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // Behavioural model: running program / halted flag / pc / retired count.
   bit m_run;
   bit m_halt;
   int m_pc;
   int m_cnt;

   function automatic int exp_count();
`ifdef FETCH_PERF_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run  = 0;
      m_halt = 0;
      m_pc   = 0;
      m_cnt  = 0;
   endtask

   task automatic model_step();
      int off;
      if (!rst_n) begin
         model_reset();
      end else if (!m_run) begin
         if (bus.start) begin
            m_run  = 1;
            m_halt = 0;
            m_pc   = int'(bus.start_addr);
            m_cnt  = 0;
         end
      end else if (!bus.stall) begin
         if (m_cnt < 65535) m_cnt++;
         if (bus.halt) begin
            m_run  = 0;
            m_halt = 1;
         end else if (bus.jump_en) begin
            m_pc = int'(bus.jump_target);
         end else if (bus.branch_en) begin
            off  = int'(bus.branch_off);
            if (off >= 128) off = off - 256;
            m_pc = (m_pc + off + 65536) % 65536;
         end else begin
            m_pc = (m_pc + 1) % 65536;
         end
      end
   endtask

   task automatic check_all();
      chk("pc_out", 32'(bus.pc_out), 32'(m_pc));
      chk("busy", 32'(bus.busy), 32'(m_run));
      chk("done", 32'(bus.done), 32'(m_halt));
      chk("instr_valid", 32'(bus.instr_valid), 32'(m_run && !bus.stall));
      chk("instr_count", 32'(bus.instr_count), 32'(exp_count()));
   endtask

   // One clock: check mid-cycle, advance the model at the edge, return just after it.
   task automatic cyc();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      bus.start       = 1'b0;
      bus.start_addr  = '0;
      bus.stall       = 1'b0;
      bus.halt        = 1'b0;
      bus.branch_en   = 1'b0;
      bus.branch_off  = '0;
      bus.jump_en     = 1'b0;
      bus.jump_target = '0;
   endtask

   initial begin
      model_reset();
      clear_inputs();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();

      // Start at 0x0010, three sequential words, then halt at 0x0013.
      bus.start = 1'b1; bus.start_addr = 16'h0010;
      cyc();
      bus.start = 1'b0;
      chk("first_pc", 32'(bus.pc_out), 32'h0010);
      cyc(); cyc(); cyc();
      chk("seq_pc", 32'(bus.pc_out), 32'h0013);
      bus.halt = 1'b1;
      cyc();
      bus.halt = 1'b0;
      chk("halt_pc", 32'(bus.pc_out), 32'h0013);
      chk("halt_done", 32'(bus.done), 32'h1);
      chk("halt_busy", 32'(bus.busy), 32'h0);
`ifdef FETCH_PERF_EN
      chk("halt_count", 32'(bus.instr_count), 32'd4);
`endif
      // Control inputs are ignored in DONE.
      bus.branch_en = 1'b1; bus.jump_en = 1'b1; bus.jump_target = 16'h4444;
      cyc();
      clear_inputs();
      chk("done_hold_pc", 32'(bus.pc_out), 32'h0013);

      // Stall with branch held, then release with offset -4.
      bus.start = 1'b1; bus.start_addr = 16'h0020;
      cyc();
      bus.start = 1'b0;
      bus.stall = 1'b1; bus.branch_en = 1'b1; bus.branch_off = 8'hFC;
      cyc(); cyc();
      chk("stall_pc", 32'(bus.pc_out), 32'h0020);
      bus.stall = 1'b0;
      cyc();
      bus.branch_en = 1'b0;
      chk("branch_back", 32'(bus.pc_out), 32'h001C);

      // Jump beats branch.
      bus.jump_en = 1'b1; bus.jump_target = 16'h0005;
      cyc();
      chk("jump_pc", 32'(bus.pc_out), 32'h0005);
      bus.jump_target = 16'h1234; bus.branch_en = 1'b1; bus.branch_off = 8'h03;
      cyc();
      clear_inputs();
      chk("jump_wins", 32'(bus.pc_out), 32'h1234);

      // Start in FETCH is ignored.
      bus.start = 1'b1; bus.start_addr = 16'h5555;
      cyc();
      bus.start = 1'b0;
      chk("start_in_fetch", 32'(bus.pc_out), 32'h1235);

      // Halt beats jump; then wrap tests.
      bus.halt = 1'b1; bus.jump_en = 1'b1; bus.jump_target = 16'h7777;
      cyc();
      clear_inputs();
      chk("halt_wins", 32'(bus.pc_out), 32'h1235);
      bus.start = 1'b1; bus.start_addr = 16'hFFFF;
      cyc();
      bus.start = 1'b0;
      chk("wrap_start", 32'(bus.pc_out), 32'hFFFF);
      chk("count_cleared", 32'(bus.instr_count), 32'h0);
      cyc();
      chk("wrap_pc", 32'(bus.pc_out), 32'h0000);
      bus.branch_en = 1'b1; bus.branch_off = 8'h80;
      cyc();
      bus.branch_en = 1'b0;
      chk("branch_neg_wrap", 32'(bus.pc_out), 32'hFF80);

      // Asynchronous reset mid-FETCH at 0x0042.
      bus.jump_en = 1'b1; bus.jump_target = 16'h0042;
      cyc();
      clear_inputs();
      chk("pre_reset_pc", 32'(bus.pc_out), 32'h0042);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_pc", 32'(bus.pc_out), 32'h0);
      chk("async_rst_busy", 32'(bus.busy), 32'h0);
      chk("async_rst_done", 32'(bus.done), 32'h0);
      bus.start = 1'b1; bus.start_addr = 16'h0099;
      cyc(); cyc();
      chk("start_in_reset", 32'(bus.pc_out), 32'h0);
      bus.start = 1'b0;
      rst_n = 1'b1;
      cyc();

      // Halt at 0x0030, restart from DONE at 0x0100.
      bus.start = 1'b1; bus.start_addr = 16'h002E;
      cyc();
      bus.start = 1'b0;
      cyc(); cyc();
      bus.halt = 1'b1;
      cyc();
      bus.halt = 1'b0;
      chk("halt30_pc", 32'(bus.pc_out), 32'h0030);
      chk("halt30_done", 32'(bus.done), 32'h1);
      bus.start = 1'b1; bus.start_addr = 16'h0100;
      cyc();
      bus.start = 1'b0;
      chk("restart_pc", 32'(bus.pc_out), 32'h0100);
      chk("restart_done", 32'(bus.done), 32'h0);
      chk("restart_count", 32'(bus.instr_count), 32'h0);
      cyc(); cyc();
      chk("restart_pc2", 32'(bus.pc_out), 32'h0102);
`ifdef FETCH_PERF_EN
      chk("restart_count2", 32'(bus.instr_count), 32'd2);
`endif

      // Random control traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bus.start       = ($urandom_range(0, 3) == 0);
         bus.start_addr  = 16'($urandom);
         bus.stall       = ($urandom_range(0, 3) == 0);
         bus.halt        = ($urandom_range(0, 15) == 0);
         bus.jump_en     = ($urandom_range(0, 7) == 0);
         bus.jump_target = 16'($urandom);
         bus.branch_en   = ($urandom_range(0, 3) == 0);
         bus.branch_off  = 8'($urandom);
         cyc();
      end
      clear_inputs();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
